// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the register slave and the AXI-Lite master side.
// Holds bus widths, response encodings and a register-index range check.
package axil_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned ADDR_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word index is addr[31:2]; the low two byte-offset bits never select a register.
  function automatic logic addr_in_range(logic [ADDR_W-1:0] addr, int unsigned num_regs);
    return ({2'b00, addr[ADDR_W-1:2]} < num_regs);
  endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Bank of NumRegs 32-bit registers with one byte-strobed write port and one
// combinational read port.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset (all registers -> ResetVal)
//   we_i, waddr_i, wdata_i, wstrb_i : write port, byte i written iff wstrb_i[i]
//   raddr_i, rdata_o : read port, shows the current (pre-write) register value
//   regs_o : all registers flattened, register k on bits [32k+31:32k]
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int unsigned       NumRegs  = 8,
  parameter logic [DATA_W-1:0] ResetVal = '0,
  parameter int unsigned       IdxW     = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      we_i,
  input  logic [IdxW-1:0]           waddr_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic [STRB_W-1:0]         wstrb_i,
  input  logic [IdxW-1:0]           raddr_i,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [DATA_W*NumRegs-1:0] regs_o
);

  logic [DATA_W-1:0] regs_q [NumRegs];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumRegs; k++) begin
        regs_q[k] <= ResetVal;
      end
    end else if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) begin
          regs_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata_o = regs_q[raddr_i];
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NumRegs; k++) begin
      regs_o[DATA_W*k +: DATA_W] = regs_q[k];
    end
  end

endmodule

// File: rtl/axil_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
// One outstanding write and one outstanding read; the two paths are independent.
// Ports:
//   aclk, aresetn        : clock, synchronous active-low reset
//   s_axi_aw*/w*/b*      : write address, write data and write response channels
//   s_axi_ar*/r*         : read address and read data channels
//   regs_o               : register k on bits [32k+31:32k]
//   wr_stb_o             : one-cycle pulse on bit k when register k is written
// All outputs come straight from flops, so no valid/ready input reaches an output
// combinationally.
module axil_slave_regs
  import axil_pkg::*;
#(
  parameter int unsigned       NUM_REGS  = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [ADDR_W-1:0]          s_axi_awaddr,
  input  logic [2:0]                 s_axi_awprot,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [DATA_W-1:0]          s_axi_wdata,
  input  logic [STRB_W-1:0]          s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [ADDR_W-1:0]          s_axi_araddr,
  input  logic [2:0]                 s_axi_arprot,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [DATA_W-1:0]          s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [DATA_W*NUM_REGS-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_stb_o
);

  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Holds readies low for the first cycle after reset release.
  logic rdy_q;

  logic              aw_held_q, aw_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              w_held_q, w_held_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;

  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              aw_hs, w_hs, ar_hs;
  logic              commit, wr_in_range, rd_in_range, bank_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [IdxW-1:0]   wr_idx, rd_idx;
  logic [DATA_W-1:0] bank_rdata;

  always_comb begin
    s_axi_awready = rdy_q & ~aw_held_q & ~bvalid_q;
    s_axi_wready  = rdy_q & ~w_held_q & ~bvalid_q;
    s_axi_arready = rdy_q & ~rvalid_q;
    s_axi_bvalid  = bvalid_q;
    s_axi_bresp   = bresp_q;
    s_axi_rvalid  = rvalid_q;
    s_axi_rresp   = rresp_q;
    s_axi_rdata   = rdata_q;
    wr_stb_o      = wr_stb_q;
  end

  always_comb begin
    aw_hs = s_axi_awvalid & s_axi_awready;
    w_hs  = s_axi_wvalid & s_axi_wready;
    ar_hs = s_axi_arvalid & s_axi_arready;

    // A channel completing this cycle is used directly so commit needs no extra cycle.
    wr_addr = aw_held_q ? awaddr_q : s_axi_awaddr;
    wr_data = w_held_q ? wdata_q : s_axi_wdata;
    wr_strb = w_held_q ? wstrb_q : s_axi_wstrb;

    commit      = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    wr_in_range = addr_in_range(wr_addr, NUM_REGS);
    rd_in_range = addr_in_range(s_axi_araddr, NUM_REGS);
    wr_idx      = wr_addr[IdxW+1:2];
    rd_idx      = s_axi_araddr[IdxW+1:2];
    bank_we     = commit & wr_in_range;
  end

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_stb_d  = '0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end

    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_in_range ? RESP_OKAY : RESP_SLVERR;
      if (wr_in_range) begin
        wr_stb_d[wr_idx] = 1'b1;
      end
    end else if (bvalid_q && s_axi_bready) begin
      // Response accepted: free both holding slots for the next write.
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = rd_in_range ? bank_rdata : '0;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rdy_q     <= 1'b0;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_stb_q  <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      rdy_q     <= 1'b1;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wr_stb_q  <= wr_stb_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Read port sees the pre-write value when a read and a commit share a cycle.
  axil_reg_bank #(
    .NumRegs  (NUM_REGS),
    .ResetVal (RESET_VAL),
    .IdxW     (IdxW)
  ) u_bank (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .we_i    (bank_we),
    .waddr_i (wr_idx),
    .wdata_i (wr_data),
    .wstrb_i (wr_strb),
    .raddr_i (rd_idx),
    .rdata_o (bank_rdata),
    .regs_o  (regs_o)
  );

  // Protection bits and byte offsets carry no meaning for this register bank.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], s_axi_araddr[1:0]};

endmodule

// File: doc/axil_slave_regs.md
# axil_slave_regs

AXI4-Lite slave (responder) exposing a bank of NUM_REGS 32-bit read/write control registers to a bus master. It is the far end of our AXI-Lite master: the master's write/read transactions land here, and register contents are presented as a flat bus to user logic. Single outstanding write and single outstanding read; the write and read paths are independent.

## Interface
- NUM_REGS, 8: number of 32-bit registers, 1..256; byte address space 0 .. 4*NUM_REGS-1.
- RESET_VAL, 32'h0000_0000: value loaded into every register on reset.

- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  synchronous, active-low reset.
- s_axi_awaddr  in  32  write byte address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid / s_axi_awready  in / out  1  write address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
- s_axi_wvalid / s_axi_wready  in / out  1  write data handshake.
- s_axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- s_axi_bvalid / s_axi_bready  out / in  1  write response handshake.
- s_axi_araddr  in  32  read byte address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid / s_axi_arready  in / out  1  read address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  OKAY / SLVERR.
- s_axi_rvalid / s_axi_rready  out / in  1  read data handshake.
- regs_o  out  32*NUM_REGS  register k on bits [32k+31:32k].
- wr_stb_o  out  NUM_REGS  one-cycle pulse, bit k when register k written.

## Operation
- Decode: index = addr[31:2]; addr[1:0] ignored. index >= NUM_REGS -> out of range.
- Write path: AW and W accepted independently, either order or same cycle; each latched into a holding register (aw_held, w_held). awready = rdy & !aw_held & !bvalid; wready = rdy & !w_held & !bvalid; rdy is a register cleared by reset, set on the first cycle aresetn is high.
- When both are held (or both complete this cycle), commit: in-range -> byte i of register updated iff wstrb[i], wr_stb_o[index] pulses, bresp OKAY (wstrb=4'h0 still OKAY and pulses, no data change); out-of-range -> no register change, no pulse, bresp SLVERR.
- bvalid holds, bresp stable, until bready; on the bready cycle aw_held/w_held clear; awready/wready return high next cycle.
- Read path: arready = rdy & !rvalid. On AR handshake, rdata/rresp captured: in-range -> register value, OKAY; out-of-range -> 32'h0, SLVERR. rvalid holds, rdata stable, until rready.
- Write and read to the same register in the same commit/handshake cycle: read returns the pre-write value.
- Reset (any time, including mid-transaction): all registers -> RESET_VAL, held address/data discarded, bvalid/rvalid/wr_stb_o -> 0, no response issued for the aborted transaction.

## Timing
- Reset values: awready 0, wready 0, arready 0, bvalid 0, bresp 2'b00, rvalid 0, rresp 2'b00, rdata 0, wr_stb_o 0, regs_o all RESET_VAL. Readies go high one cycle after aresetn rises.
- Write latency: last of AW/W handshake in cycle N -> regs_o updated, wr_stb_o pulse and bvalid high in cycle N+1.
- Read latency: AR handshake in cycle N -> rvalid high with data in cycle N+1.
- Back-to-back: bready in N+1 -> next AW/W accepted earliest N+2 (max one write per 2 cycles); same for reads.
- No combinational path from any valid/ready input to any output.

## Structure
- Package axil_pkg: RESP_OKAY 2'b00, RESP_SLVERR 2'b10, DATA_W 32, STRB_W 4, ADDR_W 32; shared with the AXI-Lite master side.
- One sub-module: axil_reg_bank (register array, byte-strobe write port, combinational read port, reset to RESET_VAL); top holds the handshake/decode logic.

## Test plan
- Reset then AW+W same cycle, addr 0x04, data 0xDEADBEEF, wstrb 0xF -> bvalid next cycle, bresp OKAY, regs_o[63:32]=0xDEADBEEF, wr_stb_o=8'h02 one cycle.
- W first (0x000000AA, wstrb 0x1), AW to 0x04 three cycles later -> only byte 0 changes, reg1=0xDEADBEAA; awready stays high, wready low while waiting.
- Read 0x04 with rready held low 4 cycles -> rvalid/rdata=0xDEADBEAA stable throughout, arready low until rready accepted.
- Write and read to 0x20 (NUM_REGS=8) -> bresp SLVERR, rresp SLVERR, rdata 0, no wr_stb_o, regs unchanged.
- Write reg 2 commit cycle coincides with AR to 0x08 -> rdata old value; following read returns new value.
- aresetn low for one cycle while bvalid pending -> bvalid drops, all regs = RESET_VAL, readies high one cycle after release, no stale response.
